ram_access_ctrl: RTL and testbench

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

---
 rtl/ram_access_pkg.sv | 20 ++
 rtl/ram_lane.sv | 19 +
 rtl/ram_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ram_access_pkg.sv
// Shared types and constants for the byte-laned RAM access controller.
package ram_access_pkg;

  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'd0,
    MODE_HALF = 2'd1,
    MODE_WORD = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    RELEASE
  } state_t;

endpackage

// File: rtl/ram_lane.sv
// One byte-wide RAM lane: synchronous write, registered read, no reset on storage.
module ram_lane #(
  parameter int unsigned DEPTH_W = 7
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] idx,
  input  logic [7:0]         wdata,
  output logic [7:0]         q
);

  logic [7:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    q <= mem[idx];
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Four-phase handshake controller over four big-endian byte lanes.
// Optional macro RAM_ACCESS_ALIGN_CHECK_EN faults misaligned half/word transfers instead of force-aligning.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              moc,
  output logic              fault
);

  state_t              state, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  mode_t               mode_q;
  logic [31:0]         wdata_q;
  logic [3:0]          cnt;
  logic                accept, last, bad;
  logic [NUM_LANES-1:0] lane_en, lane_we;
  logic [7:0]          lane_wd [NUM_LANES];
  logic [7:0]          lane_q  [NUM_LANES];
  logic [ADDR_W-3:0]   idx;
  logic [31:0]         rd_word;

`ifdef RAM_ACCESS_ALIGN_CHECK_EN
  always_comb
    bad = (mode_q == MODE_RSVD) ||
          ((mode_q == MODE_HALF) && addr_q[0]) ||
          ((mode_q == MODE_WORD) && (addr_q[1:0] != 2'b00));
`else
  // Misaligned offsets are ignored below: half uses only addr[1], word no offset bits.
  always_comb bad = (mode_q == MODE_RSVD);
`endif

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE:    if (req) begin state_d = ACCESS; accept = 1'b1; end
      ACCESS: begin
        last = bad || (cnt == 4'(LAT - 1));
        if (last) state_d = DONE;
      end
      DONE:    if (!req) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb moc = (state == DONE);

  // Read index follows the live address in IDLE so lane data is ready after one ACCESS cycle.
  always_comb idx = (state == IDLE) ? addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];

  always_comb begin
    lane_en = '0;
    case (mode_q)
      MODE_BYTE: lane_en[addr_q[1:0]] = 1'b1;
      MODE_HALF: lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      MODE_WORD: lane_en = 4'b1111;
      default:   lane_en = '0;
    endcase
    lane_we = '0;
    if (rst_n && (state == ACCESS) && last && we_q && !bad) lane_we = lane_en;
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      lane_wd[k] = wdata_q[7:0];
      if (mode_q == MODE_WORD)      lane_wd[k] = wdata_q[31-8*k -: 8];
      else if (mode_q == MODE_HALF) lane_wd[k] = (k % 2 == 0) ? wdata_q[15:8] : wdata_q[7:0];
    end
  end

  always_comb begin
    rd_word = '0;
    case (mode_q)
      MODE_BYTE: rd_word = {24'd0, lane_q[addr_q[1:0]]};
      MODE_HALF: rd_word = addr_q[1] ? {16'd0, lane_q[2], lane_q[3]}
                                     : {16'd0, lane_q[0], lane_q[1]};
      MODE_WORD: rd_word = {lane_q[0], lane_q[1], lane_q[2], lane_q[3]};
      default:   rd_word = '0;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    ram_lane #(.DEPTH_W(ADDR_W - 2)) u_lane (
      .clk   (clk),
      .we    (lane_we[k]),
      .idx   (idx),
      .wdata (lane_wd[k]),
      .q     (lane_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault   <= 1'b0;
      rdata   <= '0;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      mode_q  <= MODE_BYTE;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        mode_q  <= mode_t'(mode);
        wdata_q <= wdata;
        cnt     <= '0;
        fault   <= 1'b0;
      end
      if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
        if (last) begin
          fault <= bad;
          if (bad)        rdata <= '0;
          else if (!we_q) rdata <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl (default LAT=2, ADDR_W=9).
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, req, we;
  logic [8:0]  addr;
  logic [1:0]  mode;
  logic [31:0] wdata, rdata;
  logic        moc, fault;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic moc_d = 1'b0;

  ram_access_ctrl #(.ADDR_W(9), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .mode(mode),
    .wdata(wdata), .rdata(rdata), .moc(moc), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (moc && !moc_d) pulses++;
    moc_d = moc;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic w, input logic [8:0] a, input logic [1:0] m, input logic [31:0] d);
    we = w; addr = a; mode = m; wdata = d; req = 1'b1;
  endtask

  task automatic wait_moc(input string tag, output int n);
    n = 0;
    while (n < 20 && !moc) begin
      tick;
      n++;
    end
    check({tag, "_moc"}, {31'd0, moc}, 32'd1);
  endtask

  task automatic finish_xfer;
    req = 1'b0;
    tick;
    tick;
  endtask

  task automatic xfer(input string tag, input logic w, input logic [8:0] a, input logic [1:0] m,
                      input logic [31:0] d, output logic [31:0] rd, output logic flt, output int n);
    start(w, a, m, d);
    wait_moc(tag, n);
    rd  = rdata;
    flt = fault;
    finish_xfer;
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          n;
    int          p0;
    logic [7:0]  exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; mode = 2'd0; wdata = '0;
    tick; tick;
    check("rst_moc",   {31'd0, moc},   32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_rdata", rdata,          32'd0);
    rst_n = 1'b1;
    tick;

    xfer("wr_word", 1'b1, 9'h010, 2'd2, 32'hA1B2C3D4, rd, flt, n);
    check("wr_word_lat",   n,   3);
    check("wr_word_fault", {31'd0, flt}, 32'd0);
    check("wr_word_rdata", rd,  32'd0);

    for (int i = 0; i < 4; i++) begin
      xfer("rd_byte", 1'b0, 9'h010 + 9'(i), 2'd0, 32'hFFFF_FFFF, rd, flt, n);
      check("rd_byte_data",  rd, {24'd0, exp_b[i]});
      check("rd_byte_fault", {31'd0, flt}, 32'd0);
    end
    check("rd_byte_lat", n, 3);

    xfer("wr_w20", 1'b1, 9'h020, 2'd2, 32'h55667788, rd, flt, n);
    xfer("wr_half", 1'b1, 9'h022, 2'd1, 32'hFFFF1234, rd, flt, n);
    check("wr_half_rdata_kept", rd, 32'h000000D4);
    xfer("rd_w20", 1'b0, 9'h020, 2'd2, 32'h0, rd, flt, n);
    check("rd_w20", rd, 32'h55661234);
    xfer("rd_b20", 1'b0, 9'h020, 2'd0, 32'h0, rd, flt, n);
    check("rd_b20", rd, 32'h00000055);
    xfer("rd_b21", 1'b0, 9'h021, 2'd0, 32'h0, rd, flt, n);
    check("rd_b21", rd, 32'h00000066);
    xfer("rd_h22", 1'b0, 9'h022, 2'd1, 32'h0, rd, flt, n);
    check("rd_h22", rd, 32'h00001234);
    xfer("rd_h20", 1'b0, 9'h020, 2'd1, 32'h0, rd, flt, n);
    check("rd_h20", rd, 32'h00005566);

    xfer("rsvd", 1'b1, 9'h010, 2'd3, 32'hFFFFFFFF, rd, flt, n);
    check("rsvd_lat",   n, 2);
    check("rsvd_fault", {31'd0, flt}, 32'd1);
    check("rsvd_rdata", rd, 32'd0);
    xfer("rd_after_rsvd", 1'b0, 9'h010, 2'd2, 32'h0, rd, flt, n);
    check("rd_after_rsvd", rd, 32'hA1B2C3D4);

    xfer("rd_mis", 1'b0, 9'h011, 2'd2, 32'h0, rd, flt, n);
`ifdef RAM_ACCESS_ALIGN_CHECK_EN
    check("rd_mis_fault", {31'd0, flt}, 32'd1);
    check("rd_mis_rdata", rd, 32'd0);
    check("rd_mis_lat",   n, 2);
`else
    check("rd_mis_fault", {31'd0, flt}, 32'd0);
    check("rd_mis_rdata", rd, 32'hA1B2C3D4);
    check("rd_mis_lat",   n, 3);
`endif
    xfer("wr_hmis", 1'b1, 9'h013, 2'd1, 32'h0000BEEF, rd, flt, n);
    xfer("rd_hmis", 1'b0, 9'h010, 2'd2, 32'h0, rd, flt, n);
`ifdef RAM_ACCESS_ALIGN_CHECK_EN
    check("rd_hmis", rd, 32'hA1B2C3D4);
`else
    check("rd_hmis", rd, 32'hA1B2BEEF);
`endif

    xfer("wr_w50", 1'b1, 9'h050, 2'd2, 32'h01020304, rd, flt, n);
    xfer("wr_w40", 1'b1, 9'h040, 2'd2, 32'h0BADF00D, rd, flt, n);

    start(1'b1, 9'h040, 2'd2, 32'hFFFFFFFF);
    tick;
    rst_n = 1'b0; req = 1'b0;
    tick;
    check("abort_moc",   {31'd0, moc},   32'd0);
    check("abort_rdata", rdata,          32'd0);
    tick;
    rst_n = 1'b1;
    tick; tick;
    check("abort_moc_after", {31'd0, moc}, 32'd0);
    xfer("rd_w40", 1'b0, 9'h040, 2'd2, 32'h0, rd, flt, n);
    check("rd_w40", rd, 32'h0BADF00D);

    p0 = pulses;
    start(1'b0, 9'h010, 2'd0, 32'h0);
    wait_moc("b2b1", n);
    check("b2b1_rdata", rdata, 32'h000000A1);
    we = 1'b1; addr = 9'h050; mode = 2'd2; wdata = 32'hDEADBEEF;
    tick;
    check("b2b_done_hold", {31'd0, moc}, 32'd1);
    check("b2b_done_rdata", rdata, 32'h000000A1);
    req = 1'b0;
    tick;
    check("b2b_release", {31'd0, moc}, 32'd0);
    req = 1'b1;
    tick;
    we = 1'b0; addr = 9'h020; mode = 2'd2; wdata = 32'h0;
    tick;
    we = 1'b1; addr = 9'h050; mode = 2'd2; wdata = 32'hDEADBEEF;
    wait_moc("b2b2", n);
    check("b2b2_lat",   n, 2);
    check("b2b2_rdata", rdata, 32'h55661234);
    check("b2b2_fault", {31'd0, fault}, 32'd0);
    finish_xfer;
    check("b2b_pulses", pulses - p0, 2);
    xfer("rd_w50", 1'b0, 9'h050, 2'd2, 32'h0, rd, flt, n);
    check("rd_w50", rd, 32'h01020304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
